// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants and types for the UART command frame parser.
// Frame layout: SYNC, ADDR, DHI, DLO, CHK (CHK = ADDR ^ DHI ^ DLO).
package uart_cmd_parser_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        S_SYNC = 3'd0,
        S_ADDR = 3'd1,
        S_DHI  = 3'd2,
        S_DLO  = 3'd3,
        S_CHK  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_CHK  = 2'd1,
        ERR_ADDR = 2'd2,
        ERR_TMO  = 2'd3
    } err_t;

endpackage

// File: rtl/uart_cmd_parser_byte_timeout.sv
// Inter-byte timeout counter: counts idle clocks and pulses at the
// terminal count, then restarts from zero so it never wraps.
module uart_byte_timeout #(
    parameter int CLKS = 4340
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = $clog2(CLKS);
    localparam logic [CW-1:0] TC_VAL = CW'(CLKS - 1);

    logic [CW-1:0] cnt_q;

    assign tc_o = (cnt_q == TC_VAL);

    // Count idle clocks; clear on request or when the terminal count is hit.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i || tc_o) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles 5-byte command frames from the UART RX byte stream and turns
// each good frame into a one-cycle 16-bit register write.
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int         NUM_REGS     = 8,
    parameter int         ADDR_W       = 3,
    parameter int         TIMEOUT_CLKS = 4340
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_RX_DV,
    input  logic [7:0]        i_RX_Byte,
    output logic              o_Wr_En,
    output logic [ADDR_W-1:0] o_Wr_Addr,
    output logic [15:0]       o_Wr_Data,
    output logic              o_Frame_Err,
    output logic [1:0]        o_Err_Code,
    output logic              o_Busy
);

    localparam logic [8:0] NUM_REGS_L = 9'(NUM_REGS);

    state_t            state_q;
    logic [7:0]        addr_q;
    logic [7:0]        hi_q;
    logic [7:0]        lo_q;
    logic [7:0]        chk_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [15:0]       wr_data_q;
    logic              err_q;
    err_t              code_q;
    logic              tmo_clr;
    logic              tmo_tc;

    // Idle time only matters inside a frame; every byte restarts it.
    assign tmo_clr = i_RX_DV || (state_q == S_SYNC);

    uart_byte_timeout #(
        .CLKS (TIMEOUT_CLKS)
    ) u_tmo (
        .clk_i (i_Clock),
        .rst_i (i_Reset),
        .clr_i (tmo_clr),
        .en_i  (1'b1),
        .tc_o  (tmo_tc)
    );

    // Frame FSM with checksum accumulation and registered strobes.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= S_SYNC;
            addr_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            chk_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
            code_q    <= ERR_NONE;
        end else begin
            wr_en_q <= 1'b0;
            err_q   <= 1'b0;
            if (i_RX_DV) begin
                unique case (state_q)
                    S_SYNC: begin
                        if (i_RX_Byte == SYNC_BYTE) begin
                            state_q <= S_ADDR;
                        end
                    end
                    S_ADDR: begin
                        addr_q  <= i_RX_Byte;
                        chk_q   <= i_RX_Byte;
                        state_q <= S_DHI;
                    end
                    S_DHI: begin
                        hi_q    <= i_RX_Byte;
                        chk_q   <= chk_q ^ i_RX_Byte;
                        state_q <= S_DLO;
                    end
                    S_DLO: begin
                        lo_q    <= i_RX_Byte;
                        chk_q   <= chk_q ^ i_RX_Byte;
                        state_q <= S_CHK;
                    end
                    S_CHK: begin
                        state_q <= S_SYNC;
                        if (i_RX_Byte != chk_q) begin
                            err_q  <= 1'b1;
                            code_q <= ERR_CHK;
                        end else if ({1'b0, addr_q} >= NUM_REGS_L) begin
                            err_q  <= 1'b1;
                            code_q <= ERR_ADDR;
                        end else begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= addr_q[ADDR_W-1:0];
                            wr_data_q <= {hi_q, lo_q};
                        end
                    end
                    default: begin
                        state_q <= S_SYNC;
                    end
                endcase
            end else if (tmo_tc && (state_q != S_SYNC)) begin
                state_q <= S_SYNC;
                err_q   <= 1'b1;
                code_q  <= ERR_TMO;
            end
        end
    end

    assign o_Wr_En     = wr_en_q;
    assign o_Wr_Addr   = wr_addr_q;
    assign o_Wr_Data   = wr_data_q;
    assign o_Frame_Err = err_q;
    assign o_Err_Code  = code_q;
    assign o_Busy      = (state_q != S_SYNC);

endmodule
